vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates the 640x480@60 Hz raster timing consumed by display_controller and the level tile lookup.
- Divides the 100 MHz system clock into a 25 MHz pixel rate.
- Runs the horizontal and vertical pixel counters.
- Drives active-low hSync and vSync to the VGA connector.
- Drives bright, and a one-cycle frameStart pulse that display_controller uses to latch per-frame sprite positions.
- Counter space is the full raster: active area is hCount 144..783 by vCount 35..514, the coordinate space all sprite and tile logic uses.

Parameters:
CLK_DIV, 4, clk cycles per pixel; legal values 1..16
H_TOTAL, 800, pixels per line including blanking
H_SYNC, 96, hSync low for hCount 0..H_SYNC-1
H_ACT_START, 144, first visible hCount
H_ACT_END, 783, last visible hCount
V_TOTAL, 525, lines per frame
V_SYNC, 2, vSync low for vCount 0..V_SYNC-1
V_ACT_START, 35, first visible vCount
V_ACT_END, 514, last visible vCount

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
pixelTick  out  1  high for one clk every CLK_DIV clks; the counters advance on the edge that ends this cycle
hCount  out  10  horizontal position, 0..H_TOTAL-1
vCount  out  10  vertical position, 0..V_TOTAL-1
hSync  out  1  active-low horizontal sync
vSync  out  1  active-low vertical sync
bright  out  1  high when (hCount,vCount) is inside the active area
frameStart  out  1  one-clk pulse marking the start of a new frame

Behaviour:
- One clock domain only. Reset is synchronous and active-high: sampled on posedge clk, and it overrides all other activity.
- Reset values:
  - divider = 0, hCount = 0, vCount = 0, pixelTick = 0, frameStart = 0.
  - hSync = 0 and vSync = 0: position (0,0) lies inside both sync pulses.
  - bright = 0.
- Divider: counts 0..CLK_DIV-1 and wraps. pixelTick is registered and is high exactly during the clk cycle in which the divider equals CLK_DIV-1.
  - CLK_DIV = 1: pixelTick is held high continuously from the first cycle after reset.
  - Consequence: the first counter advance after reset release occurs CLK_DIV clks later.
- Counter advance, on each edge where pixelTick = 1:
  - hCount increments.
  - At H_TOTAL-1, hCount wraps to 0 and vCount increments.
  - At V_TOTAL-1 with hCount at H_TOTAL-1, vCount wraps to 0.
  - No other path changes the counters. Both counters are 10-bit; no value >= H_TOTAL or >= V_TOTAL is ever output.
- Decoded outputs (hSync, vSync, bright) are registered and computed from the next-state counters, so they always match the hCount/vCount presented in the same cycle. There is no pipeline skew and no combinational glitches at the pins.
  - hSync = !(hCount < H_SYNC)
  - vSync = !(vCount < V_SYNC)
  - bright = (H_ACT_START <= hCount <= H_ACT_END) && (V_ACT_START <= vCount <= V_ACT_END), inclusive on both ends.
- frameStart:
  - High for exactly one clk: the first cycle in which the counters read (0,0) following a wrap from (H_TOTAL-1, V_TOTAL-1).
  - Not asserted on reset release, even though the counters are (0,0).
  - Period: H_TOTAL*V_TOTAL*CLK_DIV clks, which is 1,680,000 at the defaults.
  - It always falls in vertical blanking, so positions latched on it are stable for the whole visible frame.
- Reset mid-frame: on the next edge all outputs return to their reset values and no frameStart is emitted. Counting restarts from (0,0) with a full CLK_DIV dwell.
- Reset held for multiple cycles: outputs remain at their reset values, and pixelTick stays 0 even when CLK_DIV = 1.

Test Plan:
- Reset and cadence: hold reset 3 clks, release; CLK_DIV=4 → pixelTick high on clks 4, 8, 12… after release, hCount reads 1 after the first tick, no frameStart, hSync=0.
- Line wrap: run to hCount=799, vCount=10 → the next tick gives hCount=0, vCount=11. hSync falls at hCount 0 and rises at hCount 96, in the same cycle the counter shows that value.
- Active window: scan line vCount=35 → bright first high at hCount=144 and last high at 783. Line vCount=34 and line 515 → bright never high. bright=0 throughout hCount 0..143.
- Frame wrap: run from (799,524) → the next state is (0,0) with frameStart high for exactly 1 clk and vSync=0. vSync returns to 1 at vCount=2. The gap between two consecutive frameStart pulses measures 1,680,000 clks.
- Reset mid-frame: assert reset for 1 clk at (400,300) → the next cycle reads (0,0) with all outputs at reset values and no frameStart. The first frameStart then appears one full frame later.
- CLK_DIV=1 build: pixelTick is 1 continuously after reset, hCount advances every clk, and the frameStart period is 420,000 clks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, horizontal/vertical counters and
// registered sync/bright/frameStart decodes aligned with the counters.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 783,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 514
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixelTick,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frameStart
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;
    logic             tick_next;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             frame_wrap;

    always_comb begin
        div_next   = (div_reg == DIV_W'(CLK_DIV - 1)) ? '0 : div_reg + DIV_W'(1);
        // With CLK_DIV = 1 the divider never leaves 0, so the tick stays high.
        tick_next  = (div_next == DIV_W'(CLK_DIV - 1));
        h_next     = hCount;
        v_next     = vCount;
        frame_wrap = 1'b0;
        if (pixelTick) begin
            if (hCount == 10'(H_TOTAL - 1)) begin
                h_next = '0;
                if (vCount == 10'(V_TOTAL - 1)) begin
                    v_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_next = vCount + 10'd1;
                end
            end else begin
                h_next = hCount + 10'd1;
            end
        end
    end

    // Decodes use the next-state counters so they line up with hCount/vCount.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg    <= '0;
            pixelTick  <= 1'b0;
            hCount     <= '0;
            vCount     <= '0;
            hSync      <= 1'b0;
            vSync      <= 1'b0;
            bright     <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            div_reg    <= div_next;
            pixelTick  <= tick_next;
            hCount     <= h_next;
            vCount     <= v_next;
            hSync      <= !(h_next < 10'(H_SYNC));
            vSync      <= !(v_next < 10'(V_SYNC));
            bright     <= (h_next >= 10'(H_ACT_START)) && (h_next <= 10'(H_ACT_END)) &&
                          (v_next >= 10'(V_ACT_START)) && (v_next <= 10'(V_ACT_END));
            frameStart <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds checked every cycle against a closed-form
// raster model driven by the number of clocks since the last reset.
module tb_vga_timing_gen;

    // Reduced geometry keeps full frames short; instance C uses the real 640x480 raster.
    localparam int GH = 40, GHS = 5, GHAS = 8, GHAE = 35;
    localparam int GV = 20, GVS = 2, GVAS = 4, GVAE = 17;
    localparam int AD = 4, BD = 1;
    localparam int RUN_CYCLES = 29000;

    typedef struct {
        bit tick;
        int h;
        int v;
        bit hs;
        bit vs;
        bit br;
        bit fs;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic       tick_a, hs_a, vs_a, br_a, fs_a;
    logic       tick_b, hs_b, vs_b, br_b, fs_b;
    logic       tick_c, hs_c, vs_c, br_c, fs_c;
    logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;

    vga_timing_gen #(.CLK_DIV(AD), .H_TOTAL(GH), .H_SYNC(GHS), .H_ACT_START(GHAS),
                     .H_ACT_END(GHAE), .V_TOTAL(GV), .V_SYNC(GVS), .V_ACT_START(GVAS),
                     .V_ACT_END(GVAE)) u_a (
        .clk(clk), .reset(rst_a), .pixelTick(tick_a), .hCount(h_a), .vCount(v_a),
        .hSync(hs_a), .vSync(vs_a), .bright(br_a), .frameStart(fs_a));

    vga_timing_gen #(.CLK_DIV(BD), .H_TOTAL(GH), .H_SYNC(GHS), .H_ACT_START(GHAS),
                     .H_ACT_END(GHAE), .V_TOTAL(GV), .V_SYNC(GVS), .V_ACT_START(GVAS),
                     .V_ACT_END(GVAE)) u_b (
        .clk(clk), .reset(rst_b), .pixelTick(tick_b), .hCount(h_b), .vCount(v_b),
        .hSync(hs_b), .vSync(vs_b), .bright(br_b), .frameStart(fs_b));

    vga_timing_gen #(.CLK_DIV(1)) u_c (
        .clk(clk), .reset(rst_c), .pixelTick(tick_c), .hCount(h_c), .vCount(v_c),
        .hSync(hs_c), .vSync(vs_c), .bright(br_c), .frameStart(fs_c));

    int tests = 0;
    int fails = 0;

    // Pixels elapsed after n clocks out of reset: one per tick cycle already ended.
    function automatic int pix_of(int n, int d);
        if (d == 1) return (n > 0) ? n - 1 : 0;
        return n / d;
    endfunction

    function automatic bit tick_of(int n, int d);
        return (n >= 1) && (n % d == d - 1);
    endfunction

    function automatic exp_t model(int n, int d, int ht, int hsn, int has, int hae,
                                   int vt, int vsn, int vas, int vae);
        exp_t e;
        int p;
        p      = pix_of(n, d);
        e.tick = tick_of(n, d);
        e.h    = p % ht;
        e.v    = (p / ht) % vt;
        e.hs   = !(e.h < hsn);
        e.vs   = !(e.v < vsn);
        e.br   = (e.h >= has) && (e.h <= hae) && (e.v >= vas) && (e.v <= vae);
        e.fs   = (n >= 1) && tick_of(n - 1, d) && (p % (ht * vt) == 0);
        return e;
    endfunction

    task automatic check(string name, int act, int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic cmp(string tag, exp_t e, logic t, logic [9:0] h, logic [9:0] v,
                       logic hs, logic vs, logic br, logic fs);
        check({tag, " pixelTick"}, int'(t), int'(e.tick));
        check({tag, " hCount"}, int'(h), e.h);
        check({tag, " vCount"}, int'(v), e.v);
        check({tag, " hSync"}, int'(hs), int'(e.hs));
        check({tag, " vSync"}, int'(vs), int'(e.vs));
        check({tag, " bright"}, int'(br), int'(e.br));
        check({tag, " frameStart"}, int'(fs), int'(e.fs));
    endtask

    // Clocks since each instance last sampled reset (0 in the cycle after a reset edge).
    int n_a = 0, n_b = 0, n_c = 0, cyc = 0;
    always @(posedge clk) begin
        n_a = rst_a ? 0 : n_a + 1;
        n_b = rst_b ? 0 : n_b + 1;
        n_c = rst_c ? 0 : n_c + 1;
        cyc = cyc + 1;
    end

    int last_fs_a = -1, last_fs_b = -1, gaps_a = 0, gaps_b = 0;
    always @(negedge clk) begin
        cmp("A", model(n_a, AD, GH, GHS, GHAS, GHAE, GV, GVS, GVAS, GVAE),
            tick_a, h_a, v_a, hs_a, vs_a, br_a, fs_a);
        cmp("B", model(n_b, BD, GH, GHS, GHAS, GHAE, GV, GVS, GVAS, GVAE),
            tick_b, h_b, v_b, hs_b, vs_b, br_b, fs_b);
        cmp("C", model(n_c, 1, 800, 96, 144, 783, 525, 2, 35, 514),
            tick_c, h_c, v_c, hs_c, vs_c, br_c, fs_c);

        // Frame period between consecutive pulses with no reset in between.
        if (n_a == 0) last_fs_a = -1;
        if (fs_a) begin
            if (last_fs_a >= 0) begin
                check("A frame period", cyc - last_fs_a, 3200);
                gaps_a++;
            end
            last_fs_a = cyc;
        end
        if (n_b == 0) last_fs_b = -1;
        if (fs_b) begin
            if (last_fs_b >= 0) begin
                check("B frame period", cyc - last_fs_b, 800);
                gaps_b++;
            end
            last_fs_b = cyc;
        end

        // Hand-computed anchor points.
        if (n_a == 2) check("A no tick before divider end", int'(tick_a), 0);
        if (n_a == 3) check("A first tick", int'(tick_a), 1);
        if (n_a == 4) begin
            check("A hCount after first tick", int'(h_a), 1);
            check("A hSync low after first tick", int'(hs_a), 0);
        end
        if (n_c == 1)     check("C tick from first cycle", int'(tick_c), 1);
        if (n_c == 96)    check("C hSync low at h95", int'(hs_c), 0);
        if (n_c == 97)    check("C hSync rises at h96", int'(hs_c), 1);
        if (n_c == 800)   check("C hCount 799", int'(h_c), 799);
        if (n_c == 801) begin
            check("C line wrap hCount", int'(h_c), 0);
            check("C line wrap vCount", int'(v_c), 1);
        end
        if (n_c == 28144) check("C bright off at (143,35)", int'(br_c), 0);
        if (n_c == 28145) check("C bright on at (144,35)", int'(br_c), 1);
        if (n_c == 28784) check("C bright on at (783,35)", int'(br_c), 1);
        if (n_c == 28785) check("C bright off at (784,35)", int'(br_c), 0);
    end

    initial begin
        int ra, la, rb, lb;
        ra = int'($urandom_range(13000, 15000));
        la = int'($urandom_range(1, 3));
        rb = int'($urandom_range(5000, 20000));
        lb = int'($urandom_range(1, 3));
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        for (int i = 0; i < RUN_CYCLES; i++) begin
            @(posedge clk);
            #1;
            rst_a = ((i >= ra) && (i < ra + la)) || ((i > 16000) && ($urandom_range(0, 7999) == 0));
            rst_b = ((i >= rb) && (i < rb + lb)) || ($urandom_range(0, 2999) == 0);
        end
        @(negedge clk);
        check("A frame gaps measured", int'(gaps_a > 0), 1);
        check("B frame gaps measured", int'(gaps_b > 0), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
